rcmd_gen: RTL
=============

Name: rcmd_gen

Overview:
- Upstream command stage for the timed global-reset generator. Its rcmd output feeds that generator, and it consumes the rset pulse that comes back.
- Turns either a long-press on the front-panel reset button or a single-cycle host command strobe into exactly one single-cycle rcmd pulse.
- Tracks the downstream rset acknowledge and enforces release/lockout so that one request yields one reset.

Parameters:
SYNC_STAGES, 2, synchronizer flops on the raw button input (min 2)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to change the debounced button level
HOLD_CYCLES, 50000000, debounced-pressed cycles required to fire
ACK_TIMEOUT, 16, cycles after the rcmd pulse within which rset must rise
LOCKOUT_CYCLES, 1000, quiet cycles after rset falls before new requests are accepted

Ports:
Clk  in  1  system clock, all logic on rising edge
Rstn  in  1  reset, asynchronous and active-low
btn_n  in  1  raw pushbutton, active-low, asynchronous to Clk
hcmd  in  1  host reset request, single-cycle strobe, Clk domain
rset  in  1  reset pulse returned by the downstream reset generator
rcmd  out  1  reset request to the downstream generator, single-cycle pulse
busy  out  1  high when a request is in flight (FIRE through REARM)
src  out  2  source of the last fired request: 00 none, 01 button, 10 host
err  out  1  sticky flag: ack timeout occurred; cleared on next FIRE

Behaviour:
- Rstn low (async):
  - all state returns to IDLE
  - synchronizer flops and debounced level go to 1 (released)
  - all counters go to 0
  - rcmd, busy, src, err go to 0
- Reset mid-operation aborts everything, with no rcmd glitch.
- Synchronizer: SYNC_STAGES flops on btn_n.
- Debouncer:
  - Counter resets whenever the synced level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - Counter width is sized by $clog2 and must saturate, never wrap.
- FSM states: IDLE, PRESS, FIRE, WAIT_ACK, WAIT_DONE, LOCKOUT, REARM.
- IDLE:
  - hcmd=1 -> FIRE, src<=10.
  - Else if debounced pressed -> PRESS, hold counter <= 0.
- PRESS:
  - Hold counter increments each cycle.
  - Debounced release -> IDLE.
  - hcmd=1 -> FIRE, src<=10. Host wins on the same cycle as hold completion.
  - Hold counter == HOLD_CYCLES-1 -> FIRE, src<=01.
- FIRE:
  - rcmd=1 for exactly this one cycle; err<=0.
  - Next state WAIT_ACK, timeout counter <= 0.
- WAIT_ACK:
  - rset=1 -> WAIT_DONE.
  - Timeout counter == ACK_TIMEOUT-1 with rset still 0 -> err<=1, then LOCKOUT.
- WAIT_DONE: stay while rset=1. rset=0 -> LOCKOUT, lockout counter <= 0.
- LOCKOUT: count LOCKOUT_CYCLES, then REARM.
- REARM: if debounced pressed, stay here (one press gives one reset); if released -> IDLE.
- Request filtering:
  - hcmd is ignored in every state except IDLE and PRESS; it is not queued.
  - rset rising while in IDLE or PRESS is ignored. No state change; src and err unaffected.
- Output timing: rcmd, busy, src and err are registered outputs. rcmd rises one cycle after the triggering condition is sampled.
- busy=1 in FIRE, WAIT_ACK, WAIT_DONE, LOCKOUT, REARM.
- src holds its value until the next FIRE.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACK_TIMEOUT=8, LOCKOUT_CYCLES=3. Bench model of the downstream generator: rset high 20 cycles, starting 2 cycles after rcmd.

1. Host command: hcmd pulse in IDLE -> rcmd high exactly one cycle, next cycle; src=10; busy high until LOCKOUT ends; exactly one rcmd total.
2. Bounce and short press: btn_n bounces (toggles every 2 cycles for 20 cycles), then held low 8 debounced cycles and released -> no rcmd; FSM back in IDLE.
3. Long press held through the reset: btn_n low continuously -> one rcmd after debounce plus 10 cycles; src=01; after lockout the FSM holds in REARM with no second rcmd until release, then returns to IDLE.
4. Simultaneous events: hcmd on the same cycle the hold counter hits 9 -> single rcmd, src=10. A further hcmd during WAIT_DONE -> ignored, no extra rcmd.
5. Ack timeout: downstream model disabled (rset stuck 0) -> rcmd once; err=1 after 8 cycles; LOCKOUT then IDLE. Next hcmd with the model enabled -> err cleared at FIRE.
6. Mid-operation reset: Rstn pulsed low during WAIT_DONE -> outputs 0 immediately (async); after release, IDLE with src=00 and no rcmd pulse.

Source files
------------

// File: rtl/rcmd_gen.sv
// Reset-request front end: debounced long-press or host strobe -> one single-cycle rcmd pulse, one cycle after the trigger is sampled.
// No backpressure; rset acknowledge tracking plus lockout/rearm ensures one request yields exactly one reset.
module rcmd_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int ACK_TIMEOUT     = 16,
  parameter int LOCKOUT_CYCLES  = 1000
) (
  input  logic       Clk,
  input  logic       Rstn,
  input  logic       btn_n,
  input  logic       hcmd,
  input  logic       rset,
  output logic       rcmd,
  output logic       busy,
  output logic [1:0] src,
  output logic       err
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
  localparam int ACK_W  = (ACK_TIMEOUT > 1)     ? $clog2(ACK_TIMEOUT)     : 1;
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1)  ? $clog2(LOCKOUT_CYCLES)  : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

  localparam logic [1:0] SRC_BTN  = 2'b01;
  localparam logic [1:0] SRC_HOST = 2'b10;

  typedef enum logic [2:0] {
    IDLE, PRESS, FIRE, WAIT_ACK, WAIT_DONE, LOCKOUT, REARM
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   db_q;
  logic [DB_W-1:0]        db_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [ACK_W-1:0]       ack_cnt;
  logic [LOCK_W-1:0]      lock_cnt;
  logic                   synced;
  logic                   pressed;
  logic                   fire_host;
  logic                   fire_btn;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign pressed = ~db_q;

  // Synchronizer and debouncer both reset to the released level.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      sync_q <= '1;
      db_q   <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
      if (synced == db_q) begin
        db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
        db_q   <= ~db_q;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Host strobe takes priority over hold completion and release in PRESS.
  always_comb begin
    fire_host = hcmd && ((state == IDLE) || (state == PRESS));
    fire_btn  = !hcmd && (state == PRESS) && pressed && (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state    <= IDLE;
      hold_cnt <= '0;
      ack_cnt  <= '0;
      lock_cnt <= '0;
      rcmd     <= 1'b0;
      busy     <= 1'b0;
      src      <= 2'b00;
      err      <= 1'b0;
    end else begin
      rcmd <= 1'b0;
      if (fire_host || fire_btn) begin
        state <= FIRE;
        src   <= fire_host ? SRC_HOST : SRC_BTN;
        rcmd  <= 1'b1;
        busy  <= 1'b1;
        err   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pressed) begin
              state    <= PRESS;
              hold_cnt <= '0;
            end
          end
          PRESS: begin
            if (!pressed) begin
              state <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          FIRE: begin
            state   <= WAIT_ACK;
            ack_cnt <= '0;
          end
          WAIT_ACK: begin
            if (rset) begin
              state <= WAIT_DONE;
            end else if (ack_cnt == ACK_LAST) begin
              err      <= 1'b1;
              state    <= LOCKOUT;
              lock_cnt <= '0;
            end else begin
              ack_cnt <= ack_cnt + 1'b1;
            end
          end
          WAIT_DONE: begin
            if (!rset) begin
              state    <= LOCKOUT;
              lock_cnt <= '0;
            end
          end
          LOCKOUT: begin
            if (lock_cnt == LOCK_LAST) begin
              state <= REARM;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
          REARM: begin
            // A button still held from the request that fired must be released first.
            if (!pressed) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
